seven_segment_scan_decoder: RTL and testbench
=============================================

// Module: seven_segment_scan_decoder
// PURPOSE
//  Receive side of the 4-digit multiplexed seven-segment interface: watches the active-low
//  Anode/LED_out scan, decodes each digit back to BCD and rebuilds the binary value.
//  Used in on-board loopback and self-check of the display path (e.g. showing the PC or a
//  register). num_valid fires only after MATCH_FRAMES consecutive identical, error-free frames.
// PARAMETERS
//  SYNC_STAGES    2   flops on Anode/LED_out before use (>=1)
//  SETTLE_CYCLES  4   cycles Anode+LED_out must hold unchanged before a digit is sampled (>=1)
//  MATCH_FRAMES   2   consecutive equal frames needed before num updates (>=1)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-high reset
//  Anode      in   4   scan select, active-low one-hot: 0111=thousands .. 1110=ones
//  LED_out    in   7   segments a..g, bit6=a .. bit0=g, active-low
//  num        out  14  decoded binary value, 0..9999
//  bcd        out  16  {thousands,hundreds,tens,ones} of the last accepted frame
//  num_valid  out  1   1-cycle pulse when num/bcd are updated
//  seg_error  out  1   sticky: unknown segment pattern seen; cleared by the next accepted frame
//  seq_error  out  1   1-cycle pulse: digit phase arrived out of order
// BEHAVIOUR
//  Reset: all outputs 0. FSM=WAIT_THOU. Counters, digit regs, previous-frame reg and
//   match count are cleared. Reset is honoured in any state, including mid-CONVERT.
//  Settle: a stability counter restarts whenever the synchronised {Anode,LED_out} changes.
//   A digit is sampled exactly once per phase, when the counter reaches SETTLE_CYCLES.
//   Anode=1111, or more than one zero, is a blank phase: never sampled, not an error.
//  Segment decode table (active-low): 0000001=0, 1001111=1, 0010010=2, 0000110=3,
//   1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
//   Any other pattern sets the frame's bad flag and sets seg_error.
//  FSM:
//   WAIT_THOU: sampled thousands phase -> store digit, clear bad flag, go to COLLECT(next=H).
//    Other sampled phases are ignored here, so no seq_error.
//   COLLECT: expected order is H, T, O.
//    Expected phase sampled -> store the digit; after ones, go to CONVERT.
//    Thousands phase sampled -> restart the frame (store the digit, expect H) and pulse seq_error.
//    Other unexpected phase -> pulse seq_error and go to WAIT_THOU.
//   CONVERT: 4 cycles, acc = (acc<<3)+(acc<<1)+digit, thousands first. Width 14 bits, no overflow.
//    Scan sampling continues; a thousands sample here is held and applied in WAIT_THOU.
//   COMPARE: 1 cycle.
//    bad -> match_cnt=0, drop the frame.
//    acc==prev -> match_cnt++ (saturating). Otherwise prev=acc, match_cnt=1.
//    match_cnt reaching MATCH_FRAMES -> load num/bcd, pulse num_valid, clear seg_error.
//    Further matching frames pulse num_valid again (once per frame).
//    Always returns to WAIT_THOU.
//  Latency: num_valid is asserted 6 cycles after the qualifying ones-digit sample
//   (1 store, 4 CONVERT, 1 COMPARE), plus SYNC_STAGES+SETTLE_CYCLES after the input change.
//  Simultaneous events: rst beats everything. A seg_error set and clear in the same cycle resolves to set.
// STRUCTURE
//  Shared package: segment-pattern constants (SEG_0..SEG_9, SEG_BLANK), anode phase constants
//   (AN_THOU, AN_HUND, AN_TENS, AN_ONES), FSM state encoding. The table is shared with the display driver.
//  One sub-module: seg7_to_bcd, purely combinational: 7-bit pattern -> {valid, 4-bit digit}.
//  Remaining logic (sync, settle counter, FSM, MAC, compare) stays inline.
// TESTING (scan dwell 16 cycles/phase, default parameters)
//  Scan 1234 for 3 frames -> first num_valid after frame 2 with num=1234, bcd=16'h1234.
//   Frame 3 gives a second pulse. No errors.
//  Scan 9999, then 0000 -> num=9999 (bcd 16'h9999), then num=0 after 2 frames of 0000.
//   No pulse between the two values.
//  Tens pattern 1111111 in one frame of 5678 -> seg_error=1 and no num_valid for that frame.
//   Two clean frames later: num=5678, seg_error=0.
//  Anode order 0111,1101,1011,1110 -> seq_error pulse, no num_valid.
//   A correct scan afterwards recovers within 2 frames.
//  2-cycle segment glitch (dwell < SETTLE_CYCLES) in the hundreds of 4321 -> ignored.
//   num=4321, no errors.
//  rst asserted during CONVERT -> num=0 and num_valid=0 immediately (async).
//   Full re-qualification (2 frames) is required afterwards.

Source files
------------

// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared encodings for the 4-digit multiplexed seven-segment path: segment patterns,
// anode phase selects and the scan-decoder FSM state. The display driver uses the same table.
package seven_segment_scan_decoder_pkg;

  // Active-low segments, bit6=a .. bit0=g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_ONES = 4'b1110;

  typedef enum logic [1:0] {
    WAIT_THOU = 2'd0,
    COLLECT   = 2'd1,
    CONVERT   = 2'd2,
    COMPARE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_THOU = 3'd1,
    PH_HUND = 3'd2,
    PH_TENS = 3'd3,
    PH_ONES = 3'd4
  } phase_t;

  // All-ones or multi-zero anode words are blanking gaps, not digit phases.
  function automatic phase_t anode_phase(input logic [3:0] an);
    case (an)
      AN_THOU: return PH_THOU;
      AN_HUND: return PH_HUND;
      AN_TENS: return PH_TENS;
      AN_ONES: return PH_ONES;
      default: return PH_NONE;
    endcase
  endfunction

  // Slot inside the packed BCD word: thousands in the top nibble.
  function automatic logic [1:0] digit_slot(input phase_t ph);
    case (ph)
      PH_THOU: return 2'd3;
      PH_HUND: return 2'd2;
      PH_TENS: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Purely combinational inverse of the segment table: active-low pattern -> {valid, digit}.
module seg7_to_bcd
  import seven_segment_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: valid = 1'b0;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Watches the multiplexed Anode/LED_out scan, rebuilds each 4-digit frame and publishes
// num/bcd once MATCH_FRAMES consecutive identical error-free frames have been seen.
module seven_segment_scan_decoder
  import seven_segment_scan_decoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Anode,
  input  logic [6:0]  LED_out,
  output logic [13:0] num,
  output logic [15:0] bcd,
  output logic        num_valid,
  output logic        seg_error,
  output logic        seq_error
);

  localparam int SW = 11;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_FRAMES + 1);

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] scan;
  logic [SW-1:0] last_q;
  logic [CW-1:0] settle_cnt;
  logic          changed;
  logic          sample;
  logic          take;
  logic          seg_ok;
  logic [3:0]    seg_digit;
  phase_t        ph;

  state_t          state, state_d;
  phase_t          exp_ph_q, exp_ph_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic            bad_q, bad_d;
  logic [13:0]     acc_q, acc_d;
  logic [13:0]     prev_q, prev_d;
  logic [13:0]     num_d;
  logic [15:0]     bcd_d;
  logic [1:0]      conv_q, conv_d;
  logic [MW-1:0]   match_q, match_d;
  logic            pend_q, pend_d;
  logic            pend_bad_q, pend_bad_d;
  logic [3:0]      pend_digit_q, pend_digit_d;
  logic            valid_d;
  logic            seq_d;
  logic            seg_set;
  logic            seg_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {Anode, LED_out};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign scan    = sync_q[SYNC_STAGES-1];
  assign changed = (scan != last_q);

  // Counter saturates at SETTLE_CYCLES so each stable phase yields exactly one sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      settle_cnt <= '0;
    end else if (changed) begin
      last_q     <= scan;
      settle_cnt <= '0;
    end else if (settle_cnt != CW'(SETTLE_CYCLES)) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign sample = !changed && (settle_cnt == CW'(SETTLE_CYCLES - 1));
  assign ph     = anode_phase(last_q[10:7]);
  assign take   = sample && (ph != PH_NONE);

  seg7_to_bcd u_seg7_to_bcd (
    .pattern (last_q[6:0]),
    .valid   (seg_ok),
    .digit   (seg_digit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT_THOU;
      exp_ph_q     <= PH_HUND;
      digits_q     <= '0;
      bad_q        <= 1'b0;
      acc_q        <= '0;
      prev_q       <= '0;
      conv_q       <= '0;
      match_q      <= '0;
      pend_q       <= 1'b0;
      pend_bad_q   <= 1'b0;
      pend_digit_q <= '0;
      num          <= '0;
      bcd          <= '0;
      num_valid    <= 1'b0;
      seg_error    <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      state        <= state_d;
      exp_ph_q     <= exp_ph_d;
      digits_q     <= digits_d;
      bad_q        <= bad_d;
      acc_q        <= acc_d;
      prev_q       <= prev_d;
      conv_q       <= conv_d;
      match_q      <= match_d;
      pend_q       <= pend_d;
      pend_bad_q   <= pend_bad_d;
      pend_digit_q <= pend_digit_d;
      num          <= num_d;
      bcd          <= bcd_d;
      num_valid    <= valid_d;
      seg_error    <= seg_set | (seg_error & ~seg_clr);
      seq_error    <= seq_d;
    end
  end

  always_comb begin
    state_d      = state;
    exp_ph_d     = exp_ph_q;
    digits_d     = digits_q;
    bad_d        = bad_q;
    acc_d        = acc_q;
    prev_d       = prev_q;
    conv_d       = conv_q;
    match_d      = match_q;
    pend_d       = pend_q;
    pend_bad_d   = pend_bad_q;
    pend_digit_d = pend_digit_q;
    num_d        = num;
    bcd_d        = bcd;
    valid_d      = 1'b0;
    seq_d        = 1'b0;
    seg_set      = take && !seg_ok;
    seg_clr      = 1'b0;

    case (state)
      WAIT_THOU: begin
        if (pend_q) begin
          digits_d[3] = pend_digit_q;
          bad_d       = pend_bad_q;
          pend_d      = 1'b0;
          exp_ph_d    = PH_HUND;
          state_d     = COLLECT;
        end else if (take && ph == PH_THOU) begin
          digits_d[3] = seg_digit;
          bad_d       = !seg_ok;
          exp_ph_d    = PH_HUND;
          state_d     = COLLECT;
        end
      end

      COLLECT: begin
        if (take) begin
          if (ph == exp_ph_q) begin
            digits_d[digit_slot(ph)] = seg_digit;
            bad_d = bad_q | !seg_ok;
            case (ph)
              PH_HUND: exp_ph_d = PH_TENS;
              PH_TENS: exp_ph_d = PH_ONES;
              default: begin
                acc_d   = '0;
                conv_d  = '0;
                state_d = CONVERT;
              end
            endcase
          end else if (ph == PH_THOU) begin
            // A fresh thousands digit means the scan restarted: resync on it.
            digits_d[3] = seg_digit;
            bad_d       = !seg_ok;
            exp_ph_d    = PH_HUND;
            seq_d       = 1'b1;
          end else begin
            seq_d   = 1'b1;
            state_d = WAIT_THOU;
          end
        end
      end

      CONVERT: begin
        // conv_q walks thousands..ones, i.e. slots 3..0.
        acc_d  = (acc_q << 3) + (acc_q << 1) + 14'(digits_q[~conv_q]);
        conv_d = conv_q + 2'd1;
        if (conv_q == 2'd3) state_d = COMPARE;
        if (take && ph == PH_THOU) begin
          pend_d       = 1'b1;
          pend_digit_d = seg_digit;
          pend_bad_d   = !seg_ok;
        end
      end

      COMPARE: begin
        state_d = WAIT_THOU;
        if (take && ph == PH_THOU) begin
          pend_d       = 1'b1;
          pend_digit_d = seg_digit;
          pend_bad_d   = !seg_ok;
        end
        if (bad_q) begin
          match_d = '0;
        end else begin
          if (acc_q == prev_q) begin
            if (match_q != MW'(MATCH_FRAMES)) match_d = match_q + 1'b1;
          end else begin
            prev_d  = acc_q;
            match_d = MW'(1);
          end
          if (match_d == MW'(MATCH_FRAMES)) begin
            num_d   = acc_q;
            bcd_d   = digits_q;
            valid_d = 1'b1;
            seg_clr = 1'b1;
          end
        end
      end

      default: state_d = WAIT_THOU;
    endcase
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: drives full scan frames and compares each frame's
// result with a frame-level model of the qualify-and-publish rules.
module tb_seven_segment_scan_decoder;

  localparam int MATCH = 2;
  localparam int DWELL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic [13:0] num;
  logic [15:0] bcd;
  logic        num_valid;
  logic        seg_error;
  logic        seq_error;

  seven_segment_scan_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .Anode     (Anode),
    .LED_out   (LED_out),
    .num       (num),
    .bcd       (bcd),
    .num_valid (num_valid),
    .seg_error (seg_error),
    .seq_error (seq_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seq_cnt = 0;

  logic [29:0] exp_q[$];
  logic [29:0] got_q[$];

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  int          m_prev = 0;
  int          m_run  = 0;
  logic        m_seg  = 1'b0;
  logic [13:0] m_num  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (num_valid) got_q.push_back({num, bcd});
      if (seq_error) seq_cnt++;
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_frame(input int v, input bit bad_f);
    if (bad_f) begin
      m_run = 0;
      m_seg = 1'b1;
    end else begin
      if (v == m_prev) m_run++;
      else begin
        m_prev = v;
        m_run  = 1;
      end
      if (m_run >= MATCH) begin
        m_num = 14'(v);
        m_seg = 1'b0;
        exp_q.push_back({14'(v), to_bcd(v)});
      end
    end
  endtask

  task automatic drive_phase(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    Anode   = an;
    LED_out = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // bad_pos: slot (0=thousands..3=ones) shown as all-off, -1 for none.
  // swap: hundreds and tens phases scanned in the wrong order.
  task automatic drive_frame(input int v, input int bad_pos, input bit glitch, input bit swap);
    int d [4];
    int slot;
    logic [6:0] seg;
    d[0] = v / 1000;
    d[1] = (v / 100) % 10;
    d[2] = (v / 10) % 10;
    d[3] = v % 10;
    for (int p = 0; p < 4; p++) begin
      slot = (swap && p == 1) ? 2 : (swap && p == 2) ? 1 : p;
      seg  = (slot == bad_pos) ? 7'b1111111 : seg_tab[d[slot]];
      if (glitch && slot == 1) begin
        drive_phase(an_tab[slot], 7'b1111111, 2);
        drive_phase(an_tab[slot], seg, DWELL - 2);
      end else begin
        drive_phase(an_tab[slot], seg, DWELL);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Anode = 4'b1111;
    LED_out = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({num, bcd, num_valid, seg_error, seq_error} !== 33'd0) begin
      bad++;
      $display("FAIL reset_outputs: got num=%0d bcd=%h v=%b se=%b qe=%b want all 0",
               num, bcd, num_valid, seg_error, seq_error);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [29:0] g, e;
    seq_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      model_frame(1234, 1'b0);
      drive_frame(1234, -1, 1'b0, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL basic_frame%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
    end
    total++;
    if ({num, bcd} !== {14'd1234, 16'h1234}) begin
      bad++;
      $display("FAIL basic_value: got num=%0d bcd=%h want 1234/1234", num, bcd);
    end
    total++;
    if (seg_error !== 1'b0 || seq_cnt != 0) begin
      bad++;
      $display("FAIL basic_errors: got seg=%b seq_pulses=%0d want 0/0", seg_error, seq_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] g, e;
    int v;
    seq_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      v = (f < 2) ? 9999 : 0;
      model_frame(v, 1'b0);
      drive_frame(v, -1, 1'b0, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL b2b_frame%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
      if (f == 1) begin
        total++;
        if ({num, bcd} !== {14'd9999, 16'h9999}) begin
          bad++;
          $display("FAIL b2b_9999: got num=%0d bcd=%h want 9999/9999", num, bcd);
        end
      end
    end
    total++;
    if ({num, bcd, seg_error} !== 31'd0 || seq_cnt != 0) begin
      bad++;
      $display("FAIL b2b_zero: got num=%0d bcd=%h seg=%b seq=%0d want 0", num, bcd, seg_error, seq_cnt);
    end
  endtask

  task automatic test_seg_error();
    logic [29:0] g, e;
    seq_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      model_frame(5678, f == 0);
      drive_frame(5678, (f == 0) ? 2 : -1, 1'b0, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL seg_frame%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
      total++;
      if (seg_error !== m_seg) begin
        bad++;
        $display("FAIL seg_flag_frame%0d: got %b want %b", f, seg_error, m_seg);
      end
    end
    total++;
    if (num !== 14'd5678 || seq_cnt != 0) begin
      bad++;
      $display("FAIL seg_recover: got num=%0d seq=%0d want 5678/0", num, seq_cnt);
    end
  endtask

  task automatic test_sequence();
    logic [29:0] g, e;
    seq_cnt = 0;
    drive_frame(8642, -1, 1'b0, 1'b1);
    total++;
    if (seq_cnt != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL seq_order: got seq=%0d pulses=%0d want 1/0", seq_cnt, got_q.size());
    end
    got_q.delete();
    seq_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      model_frame(8642, 1'b0);
      drive_frame(8642, -1, 1'b0, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL seq_recover%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
    end
    total++;
    if (num !== 14'd8642 || seq_cnt != 0) begin
      bad++;
      $display("FAIL seq_value: got num=%0d seq=%0d want 8642/0", num, seq_cnt);
    end
  endtask

  task automatic test_glitch();
    logic [29:0] g, e;
    seq_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      model_frame(4321, 1'b0);
      drive_frame(4321, -1, 1'b1, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL glitch_frame%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
    end
    total++;
    if (num !== 14'd4321 || seg_error !== 1'b0 || seq_cnt != 0) begin
      bad++;
      $display("FAIL glitch_value: got num=%0d seg=%b seq=%0d want 4321/0/0", num, seg_error, seq_cnt);
    end
  endtask

  task automatic test_random();
    logic [29:0] g, e;
    int v, n, bp;
    seq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(9999, 0));
      n = int'($urandom_range(3, 1));
      for (int f = 0; f < n; f++) begin
        bp = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
        model_frame(v, bp >= 0);
        drive_frame(v, bp, 1'b0, 1'b0);
        g = (got_q.size() > 0) ? got_q[0] : 30'h0;
        e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
        total++;
        if (got_q.size() != exp_q.size() || g !== e || seg_error !== m_seg) begin
          bad++;
          $display("FAIL random_v%0d_f%0d: got %0d pulses %h seg=%b, want %0d pulses %h seg=%b",
                   v, f, got_q.size(), g, seg_error, exp_q.size(), e, m_seg);
        end
        got_q.delete();
        exp_q.delete();
      end
    end
    total++;
    if (num !== m_num || seq_cnt != 0) begin
      bad++;
      $display("FAIL random_final: got num=%0d seq=%0d want %0d/0", num, seq_cnt, m_num);
    end
  endtask

  task automatic test_reset_convert();
    logic [29:0] g, e;
    total++;
    if (num !== m_num) begin
      bad++;
      $display("FAIL rstconv_before: got num=%0d want %0d", num, m_num);
    end
    drive_phase(an_tab[0], seg_tab[7], DWELL);
    drive_phase(an_tab[1], seg_tab[3], DWELL);
    drive_phase(an_tab[2], seg_tab[5], DWELL);
    Anode   = an_tab[3];
    LED_out = seg_tab[1];
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({num, bcd, num_valid, seg_error} !== 32'd0) begin
      bad++;
      $display("FAIL rstconv_async: got num=%0d bcd=%h v=%b se=%b want 0", num, bcd, num_valid, seg_error);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (DWELL - 11) @(posedge clk);
    #1;
    m_prev = 0;
    m_run  = 0;
    m_seg  = 1'b0;
    m_num  = '0;
    got_q.delete();
    exp_q.delete();
    seq_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      model_frame(7351, 1'b0);
      drive_frame(7351, -1, 1'b0, 1'b0);
      g = (got_q.size() > 0) ? got_q[0] : 30'h0;
      e = (exp_q.size() > 0) ? exp_q[0] : 30'h0;
      total++;
      if (got_q.size() != exp_q.size() || g !== e) begin
        bad++;
        $display("FAIL rstconv_requal%0d: got %0d pulses %h, want %0d pulses %h",
                 f, got_q.size(), g, exp_q.size(), e);
      end
      got_q.delete();
      exp_q.delete();
    end
    total++;
    if ({num, bcd} !== {14'd7351, 16'h7351} || seq_cnt != 0) begin
      bad++;
      $display("FAIL rstconv_value: got num=%0d bcd=%h seq=%0d want 7351/7351/0", num, bcd, seq_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_seg_error();
    test_sequence();
    test_glitch();
    test_random();
    test_reset_convert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
